// File: rtl/tech_cg_pkg.sv
`default_nettype none
// ============================================================================
// Module : tech_cg_pkg
// Brief  : Shared types, defaults and counter sizing for the clock-gate ctrl.
// Rev    : 1.0
// ============================================================================
package tech_cg_pkg;

    typedef enum logic [1:0] {
        CG_OFF  = 2'd0,
        CG_WAKE = 2'd1,
        CG_ON   = 2'd2
    } cg_state_e;

    localparam int DEF_N_CH        = 4;
    localparam int DEF_IDLE_CYCLES = 16;
    localparam int DEF_WAKE_CYCLES = 2;

    // Wide enough to hold max(idle, wake); never narrower than one bit.
    function automatic int cnt_width(input int idle, input int wake);
        int m;
        m = (idle > wake) ? idle : wake;
        return ($clog2(m + 1) < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tech_cg.sv
`default_nettype none
// ============================================================================
// Module : tech_cg
// Brief  : Behavioural latch-based clock gate; enable captured while clk low.
// Rev    : 1.0
// ============================================================================
module tech_cg (
    input  logic clk_i,
    input  logic en_i,
    input  logic clr_ni,
    output logic clk_o
);

    logic en_lat;

    // Async clear lets a reset kill the gated clock even during a high phase.
    always_latch begin
        if (!clr_ni) begin
            en_lat = 1'b0;
        end else if (!clk_i) begin
            en_lat = en_i;
        end
    end

    assign clk_o = clk_i & en_lat;

endmodule
`default_nettype wire

// File: rtl/tech_cg_chan.sv
`default_nettype none
// ============================================================================
// Module : tech_cg_chan
// Brief  : One gated-clock channel: OFF/WAKE/ON FSM with wake and idle counts.
// Rev    : 1.0
// ============================================================================
module tech_cg_chan
    import tech_cg_pkg::*;
#(
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_en_i,
    input  logic auto_i,
    input  logic req_i,
    input  logic busy_i,
    output logic en_o,
    output logic ack_o
);

    localparam int             CNT_W     = cnt_width(IDLE_CYCLES, WAKE_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAKE_LAST = CNT_W'((WAKE_CYCLES > 0) ? WAKE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    cg_state_e        state_q;
    logic [CNT_W-1:0] wake_cnt_q;
    logic [CNT_W-1:0] idle_cnt_q;
    logic             en_q;
    logic             ack_q;
    logic             idle;

    assign idle  = auto_i & ~req_i & ~busy_i;
    assign en_o  = en_q;
    assign ack_o = ack_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= CG_OFF;
            wake_cnt_q <= '0;
            idle_cnt_q <= '0;
            en_q       <= 1'b0;
            ack_q      <= 1'b0;
        end else if (!sw_en_i) begin
            state_q    <= CG_OFF;
            wake_cnt_q <= '0;
            idle_cnt_q <= '0;
            en_q       <= 1'b0;
            ack_q      <= 1'b0;
        end else begin
            case (state_q)
                CG_OFF: begin
                    if (req_i || !auto_i) begin
                        en_q       <= 1'b1;
                        wake_cnt_q <= '0;
                        idle_cnt_q <= '0;
                        if (WAKE_CYCLES == 0) begin
                            state_q <= CG_ON;
                            ack_q   <= 1'b1;
                        end else begin
                            state_q <= CG_WAKE;
                        end
                    end
                end
                CG_WAKE: begin
                    if (wake_cnt_q == WAKE_LAST) begin
                        state_q    <= CG_ON;
                        ack_q      <= 1'b1;
                        wake_cnt_q <= '0;
                    end else begin
                        wake_cnt_q <= wake_cnt_q + CNT_ONE;
                    end
                end
                CG_ON: begin
                    // Any activity in the threshold cycle keeps the clock running.
                    if (!idle) begin
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q == IDLE_LAST) begin
                        state_q    <= CG_OFF;
                        en_q       <= 1'b0;
                        ack_q      <= 1'b0;
                        idle_cnt_q <= '0;
                    end else if (idle_cnt_q != '1) begin
                        idle_cnt_q <= idle_cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q    <= CG_OFF;
                    wake_cnt_q <= '0;
                    idle_cnt_q <= '0;
                    en_q       <= 1'b0;
                    ack_q      <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/tech_cg_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tech_cg_ctrl
// Brief  : Multi-channel clock-gate controller driving one tech_cg per domain.
// Rev    : 1.0
// ============================================================================
module tech_cg_ctrl
    import tech_cg_pkg::*;
#(
    parameter int N_CH        = DEF_N_CH,
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            test_en_i,
    input  logic [N_CH-1:0] sw_en_i,
    input  logic [N_CH-1:0] auto_i,
    input  logic [N_CH-1:0] req_i,
    input  logic [N_CH-1:0] busy_i,
    output logic [N_CH-1:0] ack_o,
    output logic [N_CH-1:0] en_o,
    output logic [N_CH-1:0] clk_o
);

    if (N_CH < 1) begin : g_bad_nch
        $error("tech_cg_ctrl: N_CH must be >= 1");
    end
    if (IDLE_CYCLES < 1) begin : g_bad_idle
        $error("tech_cg_ctrl: IDLE_CYCLES must be >= 1");
    end
    if (WAKE_CYCLES < 0) begin : g_bad_wake
        $error("tech_cg_ctrl: WAKE_CYCLES must be >= 0");
    end

    // Test bypass keeps the gate latch out of reset so scan clocks still flow.
    logic cg_clr_n;
    assign cg_clr_n = rst_n | test_en_i;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic chan_en;

        tech_cg_chan #(
            .IDLE_CYCLES (IDLE_CYCLES),
            .WAKE_CYCLES (WAKE_CYCLES)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .sw_en_i (sw_en_i[gi]),
            .auto_i  (auto_i[gi]),
            .req_i   (req_i[gi]),
            .busy_i  (busy_i[gi]),
            .en_o    (chan_en),
            .ack_o   (ack_o[gi])
        );

        assign en_o[gi] = chan_en;

        tech_cg u_cg (
            .clk_i  (clk),
            .en_i   (chan_en | test_en_i),
            .clr_ni (cg_clr_n),
            .clk_o  (clk_o[gi])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_tech_cg_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_tech_cg_ctrl
// Brief  : Self-checking bench: 4-channel default instance plus a 1-channel
//          corner instance (WAKE_CYCLES=0, IDLE_CYCLES=1).
// Rev    : 1.0
// ============================================================================
module tb_tech_cg_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       test_en;
    logic [4:0] t_sw, t_auto, t_req, t_busy;   // [3:0] -> dut A, [4] -> dut B

    logic [3:0] a_en, a_ack, a_clk;
    logic [0:0] b_en, b_ack, b_clk;

    always #5 clk = ~clk;

    tech_cg_ctrl #(.N_CH(4), .IDLE_CYCLES(16), .WAKE_CYCLES(2)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .test_en_i (test_en),
        .sw_en_i   (t_sw[3:0]),
        .auto_i    (t_auto[3:0]),
        .req_i     (t_req[3:0]),
        .busy_i    (t_busy[3:0]),
        .ack_o     (a_ack),
        .en_o      (a_en),
        .clk_o     (a_clk)
    );

    tech_cg_ctrl #(.N_CH(1), .IDLE_CYCLES(1), .WAKE_CYCLES(0)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .test_en_i (test_en),
        .sw_en_i   (t_sw[4:4]),
        .auto_i    (t_auto[4:4]),
        .req_i     (t_req[4:4]),
        .busy_i    (t_busy[4:4]),
        .ack_o     (b_ack),
        .en_o      (b_en),
        .clk_o     (b_clk)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: channel is either gated, counting down to ack, or
    // running and tracking the length of the current idle streak.
    logic [4:0] m_en, m_ack, m_prev;
    int         m_wait[5];
    int         m_run[5];

    function automatic int wake_of(input int i);
        return (i < 4) ? 2 : 0;
    endfunction

    function automatic int idle_of(input int i);
        return (i < 4) ? 16 : 1;
    endfunction

    task automatic model_reset();
        m_en  = '0;
        m_ack = '0;
        m_prev = '0;
        for (int i = 0; i < 5; i++) begin
            m_wait[i] = 0;
            m_run[i]  = 0;
        end
    endtask

    task automatic model_edge();
        for (int i = 0; i < 5; i++) begin
            if (!t_sw[i]) begin
                m_en[i]  = 1'b0;
                m_ack[i] = 1'b0;
            end else if (!m_en[i]) begin
                if (t_req[i] || !t_auto[i]) begin
                    m_en[i]   = 1'b1;
                    m_wait[i] = wake_of(i);
                    m_ack[i]  = (m_wait[i] == 0);
                    m_run[i]  = 0;
                end
            end else if (!m_ack[i]) begin
                m_wait[i]--;
                if (m_wait[i] == 0) m_ack[i] = 1'b1;
            end else if (t_auto[i] && !t_req[i] && !t_busy[i]) begin
                m_run[i]++;
                if (m_run[i] == idle_of(i)) begin
                    m_en[i]  = 1'b0;
                    m_ack[i] = 1'b0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endtask

    // One clock: advance the model, then compare 1 ns after the rising edge.
    // During the high phase the gated clock reflects the pre-edge enable.
    task automatic step();
        @(posedge clk);
        m_prev = m_en;
        model_edge();
        #1;
        chk("en_o",  {b_en, a_en},   m_en);
        chk("ack_o", {b_ack, a_ack}, m_ack);
        chk("clk_o", {b_clk, a_clk}, m_prev | {5{test_en}});
    endtask

    initial begin
        rst_n   = 1'b0;
        test_en = 1'b0;
        t_sw    = '0;
        t_auto  = '0;
        t_req   = '0;
        t_busy  = '0;
        model_reset();

        // Reset and test bypass
        repeat (2) @(posedge clk);
        #2;
        chk("rst_en",    {b_en, a_en},   5'h00);
        chk("rst_ack",   {b_ack, a_ack}, 5'h00);
        chk("rst_clk_o", {b_clk, a_clk}, 5'h00);
        test_en = 1'b1;
        @(posedge clk);
        #2;
        chk("byp_clk_hi", {b_clk, a_clk}, 5'h1f);
        chk("byp_en",     {b_en, a_en},   5'h00);
        chk("byp_ack",    {b_ack, a_ack}, 5'h00);
        @(negedge clk);
        #1;
        chk("byp_clk_lo", {b_clk, a_clk}, 5'h00);
        test_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Manual mode: ch0 (WAKE=2) and corner instance (WAKE=0)
        t_sw[0] = 1'b1;
        t_sw[4] = 1'b1;
        step();
        chk("man_en_t1",  a_en[0],  1'b1);
        chk("man_ack_t1", a_ack[0], 1'b0);
        chk("w0_en_ack",  {b_en[0], b_ack[0]}, 2'b11);
        step();
        chk("man_ack_t2", a_ack[0], 1'b0);
        step();
        chk("man_ack_t3", a_ack[0], 1'b1);
        repeat (3) step();
        t_sw[0] = 1'b0;
        step();
        chk("man_off", {a_en[0], a_ack[0]}, 2'b00);

        // Corner instance: auto gating after a single idle cycle
        t_auto[4] = 1'b1;
        step();
        chk("idle1_off", b_en[0], 1'b0);
        t_req[4] = 1'b1;
        step();
        t_req[4] = 1'b0;
        step();

        // Auto mode on ch1
        t_auto[1] = 1'b1;
        t_sw[1]   = 1'b1;
        repeat (3) step();
        chk("auto_stays_off", a_en[1], 1'b0);
        t_req[1] = 1'b1;
        step();
        t_req[1] = 1'b0;
        repeat (2) step();
        chk("auto_ack", a_ack[1], 1'b1);
        repeat (15) step();
        chk("auto_on_15", a_en[1], 1'b1);
        step();
        chk("auto_off_16", a_en[1], 1'b0);

        t_req[1] = 1'b1;
        step();
        t_req[1] = 1'b0;
        repeat (17) step();
        t_busy[1] = 1'b1;
        step();
        t_busy[1] = 1'b0;
        repeat (15) step();
        chk("busy_restart", a_en[1], 1'b1);
        step();
        chk("busy_off", a_en[1], 1'b0);

        // ch2: req at threshold, then sw_en drop during WAKE
        t_auto[2] = 1'b1;
        t_sw[2]   = 1'b1;
        t_req[2]  = 1'b1;
        step();
        t_req[2] = 1'b0;
        repeat (17) step();
        t_req[2] = 1'b1;
        step();
        chk("req_at_thr", a_en[2], 1'b1);
        t_req[2] = 1'b0;
        repeat (16) step();
        chk("req_thr_off", a_en[2], 1'b0);
        t_req[2] = 1'b1;
        step();
        t_req[2] = 1'b0;
        t_sw[2]  = 1'b0;
        step();
        chk("wake_abort", {a_en[2], a_ack[2]}, 2'b00);
        repeat (3) step();
        chk("wake_no_ack", a_ack[2], 1'b0);

        // Reset while everything is running
        t_sw   = 5'h1f;
        t_auto = 5'h00;
        t_req  = 5'h00;
        repeat (4) step();
        @(posedge clk);
        #2;
        chk("pre_rst_clk", {b_clk, a_clk}, 5'h1f);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_en",  {b_en, a_en},   5'h00);
        chk("mid_rst_ack", {b_ack, a_ack}, 5'h00);
        chk("mid_rst_clk", {b_clk, a_clk}, 5'h00);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("post_rst_en", a_en, 4'hf);
        step();
        step();
        chk("post_rst_ack", a_ack, 4'hf);

        // Randomised traffic against the model
        t_auto = 5'($urandom);
        for (int c = 0; c < 2500; c++) begin
            for (int i = 0; i < 5; i++) begin
                if ($urandom_range(0, 199) == 0) t_sw[i]   = ~t_sw[i];
                if ($urandom_range(0, 149) == 0) t_auto[i] = ~t_auto[i];
                t_req[i]  = ($urandom_range(0, 39) == 0);
                t_busy[i] = ($urandom_range(0, 49) == 0);
            end
            test_en = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
